// File: rtl/seq_csa_accum.sv
// seq_csa_accum: sequential multi-operand adder.
// Sums K unsigned N-bit words that arrive P words per beat. Each beat is folded
// into a registered carry-save (sum, carry) pair by a chain of 3:2 compressors.
// A single carry-propagate add resolves the total once all beats are in.
//
// Handshakes: a beat transfers on a rising edge where in_valid & in_ready are
// both high; the result transfers where out_valid & out_ready are both high.
// A source that sees in_ready low must hold in_valid/in_data until it rises.
//
// Optional build macro CSA_ACCUM_PIPE_EN: splits the final carry-propagate add
// into a low-half cycle and a high-half cycle (one extra cycle of latency).
module seq_csa_accum #(
    parameter int N = 8,
    parameter int K = 10,
    parameter int P = 1,
    localparam int SW = (K == 1) ? N : N + $clog2(K)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*P-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_sum
);

    localparam int BEATS      = (K + P - 1) / P;
    localparam int LAST_LANES = K - (BEATS - 1) * P;
    localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef CSA_ACCUM_PIPE_EN
    localparam int H = SW / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_RESOLVE_LO,
        S_RESOLVE_HI,
        S_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_RESOLVE,
        S_DONE
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [SW-1:0]   carry_q, carry_d;
    logic [SW-1:0]   out_sum_q, out_sum_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

`ifdef CSA_ACCUM_PIPE_EN
    logic [H-1:0]    lo_q, lo_d;
    logic            lo_cy_q, lo_cy_d;
    logic [H:0]      lo_add;
`endif

    logic            accept;
    logic            last_beat;
    logic [SW-1:0]   fold_sum;
    logic [SW-1:0]   fold_carry;
    logic [SW-1:0]   lane_x;
    logic [SW-1:0]   tmp_s;

    assign accept    = in_valid & in_ready_q;
    assign last_beat = (cnt_q == CW'(BEATS - 1));

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

    // Fold the P lanes of this beat into the carry-save pair; start from zero in IDLE.
    always_comb begin
        fold_sum   = (state_q == S_IDLE) ? '0 : sum_q;
        fold_carry = (state_q == S_IDLE) ? '0 : carry_q;
        lane_x     = '0;
        tmp_s      = '0;
        for (int j = 0; j < P; j++) begin
            lane_x = SW'(in_data[j*N +: N]);
            // Lanes past the end of the operand set only exist on the final beat.
            if (last_beat && (j >= LAST_LANES)) begin
                lane_x = '0;
            end
            tmp_s      = fold_sum ^ fold_carry ^ lane_x;
            fold_carry = ((fold_sum & fold_carry) | (fold_sum & lane_x) |
                          (fold_carry & lane_x)) << 1;
            fold_sum   = tmp_s;
        end
    end

    // Next-state, datapath and registered-output decode; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
`ifdef CSA_ACCUM_PIPE_EN
        lo_d        = lo_q;
        lo_cy_d     = lo_cy_q;
        lo_add      = {1'b0, sum_q[H-1:0]} + {1'b0, carry_q[H-1:0]};
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sum_d   = fold_sum;
                    carry_d = fold_carry;
                    if (BEATS == 1) begin
                        cnt_d   = '0;
`ifdef CSA_ACCUM_PIPE_EN
                        state_d = S_RESOLVE_LO;
`else
                        state_d = S_RESOLVE;
`endif
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    sum_d   = fold_sum;
                    carry_d = fold_carry;
                    if (last_beat) begin
                        cnt_d   = '0;
`ifdef CSA_ACCUM_PIPE_EN
                        state_d = S_RESOLVE_LO;
`else
                        state_d = S_RESOLVE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef CSA_ACCUM_PIPE_EN
            S_RESOLVE_LO: begin
                lo_d    = lo_add[H-1:0];
                lo_cy_d = lo_add[H];
                state_d = S_RESOLVE_HI;
            end
            S_RESOLVE_HI: begin
                out_sum_d = {sum_q[SW-1:H] + carry_q[SW-1:H] + (SW-H)'(lo_cy_q), lo_q};
                state_d   = S_DONE;
            end
`else
            S_RESOLVE: begin
                out_sum_d = sum_q + carry_q;
                state_d   = S_DONE;
            end
`endif
            S_DONE: begin
                // out_valid rises one cycle after entering DONE; out_sum is already stable.
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            sum_d       = '0;
            carry_d     = '0;
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_d == S_IDLE) || (state_d == S_ACCUM);
    end

    // All state, including the registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef CSA_ACCUM_PIPE_EN
            lo_q        <= '0;
            lo_cy_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef CSA_ACCUM_PIPE_EN
            lo_q        <= lo_d;
            lo_cy_q     <= lo_cy_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_csa_accum.sv
// Testbench for seq_csa_accum: one P=1 instance and one P=3 instance (N=8, K=10).
module tb_seq_csa_accum;

  localparam int N = 8;
  localparam int K = 10;
  localparam int SW = 12;
`ifdef CSA_ACCUM_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [N-1:0]  a_in_data;
  logic [SW-1:0] a_out_sum;

  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [3*N-1:0] b_in_data;
  logic [SW-1:0] b_out_sum;

  seq_csa_accum #(.N(N), .K(K), .P(1)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_sum   (a_out_sum)
  );

  seq_csa_accum #(.N(N), .K(K), .P(3)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_sum   (b_out_sum)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [SW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: the result is simply the arithmetic sum of the K real operands.
  function automatic logic [SW-1:0] ref_sum(input logic [7:0] words[$]);
    int total;
    total = 0;
    foreach (words[i]) total += int'(words[i]);
    return SW'(total);
  endfunction

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic a_send(input logic [7:0] w, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    a_in_valid = 1'b1;
    a_in_data  = w;
    n = 0;
    while (!a_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("a_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_data  = 8'($urandom);
  endtask

  task automatic b_send(input logic [23:0] d);
    int n;
    b_in_valid = 1'b1;
    b_in_data  = d;
    n = 0;
    while (!b_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("b_in_ready", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_in_data  = 24'($urandom);
  endtask

  // Called right after the last beat is accepted; pops the expected result.
  task automatic wait_result(input bit sel_b, input bit do_hs, input string nm);
    int lat;
    logic [SW-1:0] exp;
    exp = exp_q.pop_front();
    lat = 0;
    while (!(sel_b ? b_out_valid : a_out_valid) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, "_latency"}, lat, LAT);
    chk({nm, "_sum"}, sel_b ? b_out_sum : a_out_sum, exp);
    if (do_hs) begin
      @(posedge clk); #1;
      chk({nm, "_valid_drop"}, sel_b ? b_out_valid : a_out_valid, 0);
      chk({nm, "_sum_kept"}, sel_b ? b_out_sum : a_out_sum, exp);
    end
  endtask

  task automatic a_op(input logic [79:0] words, input logic [SW-1:0] exp,
                      input bit do_hs, input string nm);
    exp_q.push_back(exp);
    for (int i = 0; i < K; i++) a_send(words[i*8 +: 8], 0);
    wait_result(1'b0, do_hs, nm);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string          name;
    logic [79:0]    words;
    logic [SW-1:0]  exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] wq[$];
    logic [23:0] beat;
    logic [SW-1:0] held;

    vecs[0] = '{"seq1to10", {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 12'h037};
    vecs[1] = '{"all_ff",   {10{8'hFF}}, 12'h9F6};
    vecs[2] = '{"all_4",    {10{8'h04}}, 12'd40};
    vecs[3] = '{"all_0",    {10{8'h00}}, 12'd0};
    vecs[4] = '{"alt_80_7f", {5{8'h80, 8'h7F}}, 12'h4FB};
    vecs[5] = '{"last_ff",  {8'hFF, {9{8'h00}}}, 12'd255};

    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 1;

    // Reset state
    #2;
    chk("rst_a_in_ready", a_in_ready, 0);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_sum", a_out_sum, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_out_sum", b_out_sum, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_a_in_ready", a_in_ready, 1);

    // Table-driven operations on the P=1 instance
    for (int v = 0; v < 6; v++) a_op(vecs[v].words, vecs[v].exp, 1'b1, vecs[v].name);

    // Randomized operations with idle gaps between beats
    for (int r = 0; r < 6; r++) begin
      wq.delete();
      for (int i = 0; i < K; i++) wq.push_back(8'($urandom_range(0, 255)));
      exp_q.push_back(ref_sum(wq));
      foreach (wq[i]) a_send(wq[i], $urandom_range(0, 2));
      wait_result(1'b0, 1'b1, "a_rand");
    end

    // P=3: masked lanes on the final beat carry junk
    exp_q.push_back(12'd55);
    b_send({8'd3, 8'd2, 8'd1});
    b_send({8'd6, 8'd5, 8'd4});
    b_send({8'd9, 8'd8, 8'd7});
    b_send({8'hAA, 8'hAA, 8'd10});
    wait_result(1'b1, 1'b1, "b_mask");

    for (int r = 0; r < 4; r++) begin
      wq.delete();
      for (int i = 0; i < K; i++) wq.push_back(8'($urandom_range(0, 255)));
      exp_q.push_back(ref_sum(wq));
      for (int bt = 0; bt < 4; bt++) begin
        beat = 24'($urandom);
        for (int l = 0; l < 3; l++)
          if (bt * 3 + l < K) beat[l*8 +: 8] = wq[bt*3 + l];
        b_send(beat);
      end
      wait_result(1'b1, 1'b1, "b_rand");
    end

    // Backpressure: result held, input stalled while the next op's first word waits
    a_out_ready = 1'b0;
    a_op(vecs[0].words, 12'd55, 1'b0, "bp");
    for (int c = 0; c < 5; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'd4;
      @(posedge clk); #1;
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_out_sum", a_out_sum, 55);
      chk("bp_in_ready", a_in_ready, 0);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", a_out_valid, 0);
    a_op({10{8'h04}}, 12'd40, 1'b1, "bp_next");

    // Asynchronous reset during the third beat
    a_send(8'd1, 0);
    a_send(8'd2, 0);
    a_in_valid = 1'b1;
    a_in_data  = 8'd3;
    #3 rst_n = 1'b0;
    #1;
    chk("amid_rst_out_valid", a_out_valid, 0);
    chk("amid_rst_out_sum", a_out_sum, 0);
    chk("amid_rst_in_ready", a_in_ready, 0);
    a_in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    a_op({10{8'h04}}, 12'd40, 1'b1, "post_rst");

    // Flush after four beats; the beat presented with flush is discarded
    for (int i = 0; i < 4; i++) a_send(8'd7, 0);
    a_in_valid = 1'b1;
    a_in_data  = 8'hFF;
    a_flush    = 1'b1;
    @(posedge clk); #1;
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    chk("flush_in_ready", a_in_ready, 1);
    chk("flush_out_valid", a_out_valid, 0);
    a_op({10{8'h01}}, 12'd10, 1'b1, "post_flush");

    // Flush while a result is waiting: out_valid drops, out_sum keeps its value
    a_out_ready = 1'b0;
    a_op(vecs[1].words, 12'h9F6, 1'b0, "flush_done");
    held = 12'h9F6;
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    a_out_ready = 1'b1;
    chk("flush_done_valid", a_out_valid, 0);
    chk("flush_done_sum", a_out_sum, held);
    chk("flush_done_in_ready", a_in_ready, 1);
    a_op(vecs[0].words, 12'd55, 1'b1, "after_flush_done");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
